// File: rtl/rr_grant_pkg.sv
// Shared types and reset constants for the round-robin grant controller.
package rr_grant_pkg;

    // Controller state: no owner, or an owner currently holds the resource.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rr_state_t;

    // Reset value of the rotating priority pointer.
    localparam int unsigned PTR_RST  = 0;

    // Reset value of the grant watchdog hold counter.
    localparam int unsigned HOLD_RST = 0;

endpackage

// File: rtl/prio_enc.sv
// Combinational fixed-priority encoder: lowest set bit wins.
// Produces the one-hot winner, its binary index and a valid flag.
module prio_enc #(
    parameter int N   = 8,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   vec,
    output logic [N-1:0]   onehot,
    output logic [IDW-1:0] idx,
    output logic           valid
);

    // Scan from bit 0 upward and latch onto the first set bit.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i] && !valid) begin
                onehot[i] = 1'b1;
                idx       = IDW'(i);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter with locked grants.
// A rotating pointer selects the highest-priority requester; the winner
// keeps the grant until it signals done or drops its request.
// Optional grant watchdog: define RR_GRANT_TIMEOUT_EN to force-release an
// owner that holds for MAX_HOLD cycles; otherwise timeout is constant 0.
//
// Handshake: req is level-sensitive and must stay high while a requester
// wants or owns the resource; the owner ends its tenure by pulsing done
// (sampled only while a grant is active) or by dropping its req bit.
module rr_grant_ctrl
    import rr_grant_pkg::*;
#(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout,
    output logic           dbg_state,
    output logic [IDW-1:0] dbg_ptr
);

    // Parameter sanity, caught at elaboration.
    if (N < 2 || N > 32) begin : g_bad_n
        $error("rr_grant_ctrl: N must be within 2..32");
    end
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("rr_grant_ctrl: MAX_HOLD must be at least 2");
    end

    rr_state_t      state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;

    logic           own_req;
    logic [IDW-1:0] next_ptr;
    logic [IDW-1:0] arb_ptr;
    logic [N-1:0]   arb_vec;
    logic [N-1:0]   arb_mask;
    logic [N-1:0]   masked_vec;
    logic           expire;
    logic           rel_now;

    logic [N-1:0]   m_onehot, u_onehot, win_onehot;
    logic [IDW-1:0] m_idx, u_idx, win_idx;
    logic           m_valid, u_valid, win_valid;

    // Arbitration inputs: on a release the pointer has already moved past
    // the owner and the owner's own request is excluded.
    always_comb begin
        own_req  = req[gnt_id_q];
        next_ptr = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + 1'b1;
        if (state_q == GRANT) begin
            arb_ptr = next_ptr;
            arb_vec = req & ~gnt_q;
        end else begin
            arb_ptr = ptr_q;
            arb_vec = req;
        end
        for (int i = 0; i < N; i++) begin
            arb_mask[i] = (i >= int'(arb_ptr));
        end
        masked_vec = arb_vec & arb_mask;
    end

    prio_enc #(.N(N), .IDW(IDW)) u_enc_masked (
        .vec    (masked_vec),
        .onehot (m_onehot),
        .idx    (m_idx),
        .valid  (m_valid)
    );

    prio_enc #(.N(N), .IDW(IDW)) u_enc_unmasked (
        .vec    (arb_vec),
        .onehot (u_onehot),
        .idx    (u_idx),
        .valid  (u_valid)
    );

    // Upper (masked) half has priority; wrap to the full vector if empty.
    assign win_onehot = m_valid ? m_onehot : u_onehot;
    assign win_idx    = m_valid ? m_idx    : u_idx;
    assign win_valid  = m_valid | u_valid;

`ifdef RR_GRANT_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;

    assign expire = (state_q == GRANT) && (hold_q == HW'(MAX_HOLD - 1));
`else
    assign expire = 1'b0;
`endif

    assign rel_now = (state_q == GRANT) && (done || !own_req || expire);

    // Next-state, pointer and grant computation.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d  = GRANT;
                    gnt_d    = win_onehot;
                    gnt_id_d = win_idx;
                end else begin
                    gnt_d    = '0;
                    gnt_id_d = '0;
                end
            end
            GRANT: begin
                if (rel_now) begin
                    ptr_d = next_ptr;
                    if (win_valid) begin
                        gnt_d    = win_onehot;
                        gnt_id_d = win_idx;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
            end
        endcase
    end

    // FSM and registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= IDW'(PTR_RST);
            gnt_q    <= '0;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
        end
    end

`ifdef RR_GRANT_TIMEOUT_EN
    // Watchdog: count held cycles, restart on any new grant.
    always_comb begin
        hold_d    = hold_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            hold_d = HW'(HOLD_RST);
        end else if (rel_now) begin
            hold_d    = HW'(HOLD_RST);
            timeout_d = expire && !done && own_req;
        end else begin
            hold_d = hold_q + 1'b1;
        end
    end

    // Hold counter and registered timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= HW'(HOLD_RST);
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = (state_q == GRANT);
    assign dbg_state = state_q;
    assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Self-checking bench for rr_grant_ctrl: directed vector table, hand
// sequences for the watchdog, and randomized traffic against a scan model.
module tb_rr_grant_ctrl;

    localparam int N   = 8;
    localparam int IDW = 3;
`ifdef RR_GRANT_TIMEOUT_EN
    localparam int MH        = 4;
    localparam int HOLD_ROWS = 2;
`else
    localparam int MH        = 16;
    localparam int HOLD_ROWS = 10;
`endif

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic           done;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic           timeout;
    logic           dbg_state;
    logic [IDW-1:0] dbg_ptr;

    int checks = 0;
    int errors = 0;

    rr_grant_ctrl #(.N(N), .MAX_HOLD(MH), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    // First requester found scanning ptr, ptr+1, ... wrapping, skipping excl.
    function automatic int pick(input logic [N-1:0] r, input int p, input int excl);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (r[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    function automatic void model_step(input logic [N-1:0] r, input logic d, input logic rs);
        bit expd;
        bit rel;
        m_to = 1'b0;
        if (rs) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            m_owner = pick(r, m_ptr, -1);
            m_hold  = 0;
        end else begin
            expd = 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
            expd = (m_hold == MH - 1);
`endif
            rel = d || !r[m_owner] || expd;
            if (rel) begin
                m_to    = expd && !d && r[m_owner];
                m_ptr   = (m_owner + 1) % N;
                m_owner = pick(r, m_ptr, m_owner);
                m_hold  = 0;
            end else begin
                m_hold++;
            end
        end
    endfunction

    // ---------------- checking ----------------
    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endfunction

    // Drive one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic cycle(input logic [N-1:0] r, input logic d, input logic rs);
        req  = r;
        done = d;
        rst  = rs;
        @(posedge clk);
        model_step(r, d, rs);
        #1;
    endtask

    task automatic chk_model();
        chk("m_gnt",   32'(gnt),       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("m_id",    32'(gnt_id),    (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("m_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        chk("m_to",    32'(timeout),   32'(m_to));
        chk("m_ptr",   32'(dbg_ptr),   32'(m_ptr));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0]   req;
        logic           done;
        logic           rst;
        logic [N-1:0]   gnt;
        logic [IDW-1:0] id;
        logic           valid;
        logic [IDW-1:0] ptr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [N-1:0] r, input logic d, input logic rs,
                                input logic [N-1:0] g, input int id, input logic v, input int p);
        vec_t e;
        e.req = r; e.done = d; e.rst = rs;
        e.gnt = g; e.id = IDW'(id); e.valid = v; e.ptr = IDW'(p);
        tbl.push_back(e);
    endfunction

    initial begin
        logic [N-1:0] r;
        logic         d;
        logic         rs;

        req  = '0;
        done = 1'b0;
        rst  = 1'b1;

        // Reset and idle
        add(8'h00, 0, 1, 8'h00, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(8'h00, 0, 0, 8'h00, 0, 0, 0);
        // All requesting, done every cycle: 0..7 then wrap to 0
        add(8'hFF, 1, 0, 8'h01, 0, 1, 0);
        for (int i = 1; i < N; i++) add(8'hFF, 1, 0, 8'(1 << i), i, 1, i);
        add(8'hFF, 1, 0, 8'h01, 0, 1, 0);
        // Owner 2 is not preempted by a new request, then hands to 1
        add(8'h00, 0, 1, 8'h00, 0, 0, 0);
        add(8'h04, 0, 0, 8'h04, 2, 1, 0);
        for (int i = 0; i < HOLD_ROWS; i++) add(8'h06, 0, 0, 8'h04, 2, 1, 0);
        add(8'h06, 1, 0, 8'h02, 1, 1, 3);
        // Same hand-off with bit 5 pending: 5 wins over 1
        add(8'h00, 0, 1, 8'h00, 0, 0, 0);
        add(8'h04, 0, 0, 8'h04, 2, 1, 0);
        add(8'h26, 1, 0, 8'h20, 5, 1, 3);
        // Owner 7 drops its request: idle, pointer wraps to 0
        add(8'h00, 0, 1, 8'h00, 0, 0, 0);
        add(8'h80, 0, 0, 8'h80, 7, 1, 0);
        add(8'h00, 0, 0, 8'h00, 0, 0, 0);
        // done and request drop together: single pointer advance
        add(8'h00, 0, 1, 8'h00, 0, 0, 0);
        add(8'h05, 0, 0, 8'h01, 0, 1, 0);
        add(8'h04, 1, 0, 8'h04, 2, 1, 1);
        add(8'h04, 0, 0, 8'h04, 2, 1, 1);
        // Reset mid-grant, then re-arbitration from pointer 0
        add(8'h00, 0, 1, 8'h00, 0, 0, 0);
        add(8'h10, 0, 0, 8'h10, 4, 1, 0);
        add(8'h30, 0, 1, 8'h00, 0, 0, 0);
        add(8'h30, 0, 0, 8'h10, 4, 1, 0);

        foreach (tbl[i]) begin
            cycle(tbl[i].req, tbl[i].done, tbl[i].rst);
            chk($sformatf("row%0d_gnt", i),   32'(gnt),       32'(tbl[i].gnt));
            chk($sformatf("row%0d_id", i),    32'(gnt_id),    32'(tbl[i].id));
            chk($sformatf("row%0d_valid", i), 32'(gnt_valid), 32'(tbl[i].valid));
            chk($sformatf("row%0d_state", i), 32'(dbg_state), 32'(tbl[i].valid));
            chk($sformatf("row%0d_ptr", i),   32'(dbg_ptr),   32'(tbl[i].ptr));
            chk($sformatf("row%0d_to", i),    32'(timeout),   32'd0);
        end

        // Watchdog sequence: req=03, done never asserted
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h03, 1'b0, 1'b0);
        chk("wd_first_gnt", 32'(gnt), 32'h01);
`ifdef RR_GRANT_TIMEOUT_EN
        for (int i = 0; i < MH - 1; i++) begin
            cycle(8'h03, 1'b0, 1'b0);
            chk("wd_hold_gnt", 32'(gnt), 32'h01);
            chk("wd_hold_to",  32'(timeout), 32'd0);
        end
        cycle(8'h03, 1'b0, 1'b0);
        chk("wd_rel_gnt", 32'(gnt), 32'h02);
        chk("wd_rel_to",  32'(timeout), 32'd1);
        chk("wd_rel_ptr", 32'(dbg_ptr), 32'd1);
        cycle(8'h03, 1'b0, 1'b0);
        chk("wd_after_gnt", 32'(gnt), 32'h02);
        chk("wd_after_to",  32'(timeout), 32'd0);
`else
        for (int i = 0; i < 20; i++) begin
            cycle(8'h03, 1'b0, 1'b0);
            chk("hold_forever_gnt", 32'(gnt), 32'h01);
            chk("hold_forever_to",  32'(timeout), 32'd0);
        end
`endif

        // Randomized traffic against the scan model
        cycle(8'h00, 1'b0, 1'b1);
        r = '0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom_range(0, 255));
            d  = ($urandom_range(0, 4) == 0);
            rs = ($urandom_range(0, 199) == 0);
            cycle(r, d, rs);
            chk_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_grant_ctrl.md
# rr_grant_ctrl

Round-robin arbiter controller that shares a single downstream resource among `N` requesters with locked, handshaked grants. It wraps a masked fixed-priority encoder. A rotating pointer keeps selection fair, and the grant stays held until the winner signals completion or withdraws its request. It sits between requesting engines and the shared datapath/bus, and drives that resource's select and enable.

## Interface
- `N`, 8: number of requesters, 2..32.
- `MAX_HOLD`, 16: grant watchdog limit in cycles, ≥2. Used only with `RR_GRANT_TIMEOUT_EN`.
- `IDW`, `$clog2(N)`: width of the grant index.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N: request vector, level-sensitive.
- `done` in 1: current owner finished, sampled only in GRANT.
- `gnt` out N: one-hot grant, registered.
- `gnt_id` out IDW: binary index of the granted requester.
- `gnt_valid` out 1: a grant is active (`|gnt`).
- `timeout` out 1: one-cycle pulse on a watchdog-forced release. Tied to 0 without the macro.

## Operation
- States: `IDLE` and `GRANT`. A pointer `ptr` (IDW bits) marks the highest-priority index.
- Arbitration: the winner is the first set bit of `req` scanning `ptr, ptr+1, … N-1, 0 … ptr-1`.
  - Implement as masked encode: `req & ~((1<<ptr)-1)` first; if that is zero, fall back to unmasked `req`.
  - The lowest index wins within each half.
- `IDLE`:
  - If `|req`, load `gnt`/`gnt_id` with the winner and go to `GRANT`.
  - Otherwise stay, with `gnt=0`.
- `GRANT` release occurs when `done==1` or `req[gnt_id]==0`, or on watchdog expiry with the macro. On release:
  - `ptr <= gnt_id+1`, wrapping from `N-1` to 0.
  - Re-arbitrate in the same cycle using the new `ptr`, over `req` with the current owner's bit masked off.
  - If a winner exists, load it directly (back-to-back grant, state stays `GRANT`). Otherwise clear `gnt` and go to `IDLE`.
- No release condition: `gnt`, `gnt_id` and `ptr` hold. New requests never preempt the owner.
- `done` in `IDLE` is ignored.
- `gnt` is always one-hot or zero. `gnt_valid` equals `state==GRANT`.

## Timing
- Reset values: `gnt=0`, `gnt_id=0`, `gnt_valid=0`, `timeout=0`, `ptr=0`, state `IDLE`, hold counter 0.
- Latency: `req` asserted in cycle t while `IDLE` gives `gnt` in cycle t+1.
- Release: `done` in cycle t gives the new owner, or `gnt=0`, in cycle t+1. There are no bubble cycles between back-to-back owners.
- `done` and `req[gnt_id]` falling in the same cycle produce a single release. The pointer advances once.
- `rst` mid-grant: next cycle all outputs are at reset values and requests are re-arbitrated from `ptr=0`.
- `ptr` wraps: owner `N-1` releasing gives `ptr=0`.

## Configuration
- `RR_GRANT_TIMEOUT_EN` defined:
  - A hold counter clears on every new grant and increments each `GRANT` cycle without release.
  - When it reaches `MAX_HOLD-1` with no release, the grant is force-released as if `done`, and `timeout` pulses 1 in that release's output cycle.
  - If `done` arrives in the same cycle as expiry, the release counts as normal and `timeout` stays 0.
- Undefined: no counter logic and `timeout` is constant 0. A grant may be held indefinitely.

## Structure
- Package `rr_grant_pkg`: `typedef enum logic {IDLE, GRANT} rr_state_t`. Reset constants for `ptr` and the counter.
- Sub-module `prio_enc`: parameterized combinational fixed-priority encoder, LSB first. It takes an N-bit vector and outputs a one-hot N-bit result, an IDW index and `valid`.
- Instantiate it twice: masked and unmasked. The controller holds the FSM, `ptr`, counter and output registers.

## Test plan
- Reset, then `req=8'h00` for 5 cycles → `gnt=0`, `gnt_valid=0`, `gnt_id=0` throughout.
- From reset, `req=8'hFF` with `done` pulsed every cycle → grants 0,1,2…7,0 in successive cycles, with no gap cycles.
- Owner 2 holds while `req` gains bit 1, `done=0` for 10 cycles → `gnt` stays `8'h04`. On `done`, `ptr=3` and the next `gnt` is `8'h02` only if bits 3..7 are clear.
- `req=8'h80`, granted, then `req[7]` drops → `gnt=0`, state `IDLE` next cycle, `ptr=0`.
- Reset asserted while `gnt=8'h10` → next cycle all outputs are zero. `req=8'h30` after release → `gnt=8'h10` (`ptr=0`).
- With `RR_GRANT_TIMEOUT_EN` and `MAX_HOLD=4`, `req=8'h03` with `done` never asserted → owner 0 released after 4 cycles, `timeout` pulses once, `gnt=8'h02`.
